// File: rtl/dp_mem_init_if.sv
// ---------------------------------------------------------------------------
// dp_mem_init_if
// Bundles the port-A write, port-B read and ready signals of dp_mem_init.
//   master : drives wr_en/wr_addr/wr_data/wr_be and rd_en/rd_addr,
//            receives rd_data/rd_valid/ready
//   slave  : the memory side (opposite directions)
// Parameters DEPTH and DATA_WIDTH must match the attached dp_mem_init.
// ---------------------------------------------------------------------------
interface dp_mem_init_if #(
    parameter int DEPTH      = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int BE_WIDTH   = DATA_WIDTH / 8;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [BE_WIDTH-1:0]   wr_be;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  ready;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  rd_data, rd_valid, ready
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output rd_data, rd_valid, ready
    );
endinterface

// File: rtl/dp_mem_init.sv
// ---------------------------------------------------------------------------
// dp_mem_init
// Simple dual-port RAM (one byte-masked write port, one registered read
// port) that zeroes its whole contents after every reset before accepting
// any request.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, restarts the clearing sweep
//   bus  : dp_mem_init_if.slave
//          wr_en/wr_addr/wr_data/wr_be : byte-masked write request
//          rd_en/rd_addr               : read request
//          rd_data/rd_valid            : read result, one cycle after rd_en
//          ready                       : clearing done, requests accepted
// ---------------------------------------------------------------------------
module dp_mem_init #(
    parameter int DEPTH      = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    dp_mem_init_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int BE_WIDTH   = DATA_WIDTH / 8;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    // One bit wider than an address so DEPTH itself is representable when
    // DEPTH is a power of two.
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  ready_q;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  clear_wr;
    logic                  user_wr;
    logic                  user_rd;
    logic                  wr_in_range;
    logic                  rd_in_range;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Address slots beyond DEPTH exist only when DEPTH is not a power of two.
    assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_EXT);

    // State, sweep counter and ready flag. ready follows the next state so it
    // is a flop that is high exactly while the FSM sits in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= (state_d == RUN);
        end
    end

    // Next state and request qualification. The sweep counter parks on the
    // last address instead of wrapping, so it can never alias address 0.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clear_wr  = 1'b0;
        user_wr   = 1'b0;
        user_rd   = 1'b0;
        case (state_q)
            CLEAR: begin
                clear_wr = 1'b1;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d = RUN;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_ONE;
                end
            end
            RUN: begin
                user_wr = bus.wr_en && wr_in_range;
                user_rd = bus.rd_en;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Storage array, deliberately without reset: contents are zeroed only by
    // the sweep. Byte lanes with a clear enable keep their old value.
    always_ff @(posedge clk) begin
        if (clear_wr) begin
            mem[clr_cnt_q] <= '0;
        end else if (user_wr) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (bus.wr_be[i]) begin
                    mem[bus.wr_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
                end
            end
        end
    end

    // Registered read port. Sampling mem before the same-edge write lands
    // gives read-first behaviour on an address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= user_rd;
            if (user_rd) begin
                rd_data_q <= rd_in_range ? mem[bus.rd_addr] : '0;
            end
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.ready    = ready_q;
endmodule

// File: tb/tb_dp_mem_init.sv
// ---------------------------------------------------------------------------
// tb_dp_mem_init
// Drives one request stream into two dp_mem_init instances (DEPTH=32 and
// DEPTH=20, both with 5-bit addresses) and compares every cycle against an
// array model of each memory.
// ---------------------------------------------------------------------------
module tb_dp_mem_init;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [3:0]    wr_be;
    logic          rd_en;
    logic [AW-1:0] rd_addr;

    always #5 clk = ~clk;

    dp_mem_init_if #(.DEPTH(32), .DATA_WIDTH(DW)) bus_a ();
    dp_mem_init_if #(.DEPTH(20), .DATA_WIDTH(DW)) bus_b ();

    assign bus_a.wr_en   = wr_en;
    assign bus_a.wr_addr = wr_addr;
    assign bus_a.wr_data = wr_data;
    assign bus_a.wr_be   = wr_be;
    assign bus_a.rd_en   = rd_en;
    assign bus_a.rd_addr = rd_addr;
    assign bus_b.wr_en   = wr_en;
    assign bus_b.wr_addr = wr_addr;
    assign bus_b.wr_data = wr_data;
    assign bus_b.wr_be   = wr_be;
    assign bus_b.rd_en   = rd_en;
    assign bus_b.rd_addr = rd_addr;

    dp_mem_init #(.DEPTH(32), .DATA_WIDTH(DW)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    dp_mem_init #(.DEPTH(20), .DATA_WIDTH(DW)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    int          checks = 0;
    int          errors = 0;
    int          depth [2] = '{32, 20};
    logic [31:0] mdl_mem [2][32];
    int          since [2];
    logic [31:0] exp_data [2];
    logic        exp_valid [2];

    // Model: an instance ignores everything for its first DEPTH edges after
    // reset, after which the array is all zeros and requests are honoured.
    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            since[d]     = 0;
            exp_data[d]  = '0;
            exp_valid[d] = 1'b0;
        end
    endtask

    task automatic modelEdge();
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                if (since[d] < depth[d]) begin
                    exp_valid[d] = 1'b0;
                    if (since[d] == depth[d] - 1) begin
                        for (int a = 0; a < 32; a++) mdl_mem[d][a] = '0;
                    end
                    since[d]++;
                end else begin
                    if (rd_en) begin
                        exp_valid[d] = 1'b1;
                        exp_data[d]  = (int'(rd_addr) < depth[d]) ? mdl_mem[d][rd_addr] : 32'h0;
                    end else begin
                        exp_valid[d] = 1'b0;
                    end
                    if (wr_en && int'(wr_addr) < depth[d]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wr_be[b]) mdl_mem[d][wr_addr][8*b +: 8] = wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    endtask

    task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string step);
        logic [31:0] obs_data;
        logic        obs_valid;
        logic        obs_ready;
        logic        exp_ready;
        for (int d = 0; d < 2; d++) begin
            obs_data  = (d == 0) ? bus_a.rd_data  : bus_b.rd_data;
            obs_valid = (d == 0) ? bus_a.rd_valid : bus_b.rd_valid;
            obs_ready = (d == 0) ? bus_a.ready    : bus_b.ready;
            exp_ready = !rst && (since[d] >= depth[d]);
            check1($sformatf("%s D%0d rd_data", step, depth[d]), obs_data, exp_data[d]);
            check1($sformatf("%s D%0d rd_valid", step, depth[d]), {31'b0, obs_valid}, {31'b0, exp_valid[d]});
            check1($sformatf("%s D%0d ready", step, depth[d]), {31'b0, obs_ready}, {31'b0, exp_ready});
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                 input logic [3:0] be, input logic re, input logic [AW-1:0] ra);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        wr_be   = be;
        rd_en   = re;
        rd_addr = ra;
    endtask

    task automatic applyRandom();
        applyStimulus(1'(($urandom)), AW'($urandom_range(31, 0)), $urandom,
                      4'($urandom), 1'(($urandom)), AW'($urandom_range(31, 0)));
    endtask

    task automatic tick(input string step);
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput(step);
    endtask

    // Reset is raised between edges so its asynchronous effect is visible
    // before the next clock.
    task automatic doReset(input string step);
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput(step);
        tick({step, "_hold"});
        tick({step, "_hold"});
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
        doReset("reset");

        // Requests during the sweep (the DEPTH=20 copy goes live partway).
        for (int i = 0; i < 34; i++) begin
            applyRandom();
            tick("clear_rand");
        end

        for (int a = 0; a < 32; a++) begin
            applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(a));
            tick("read_all");
        end

        // Byte-masked merge at address 5.
        applyStimulus(1'b1, 5'd5, 32'hAABBCCDD, 4'hF, 1'b0, '0);
        tick("merge_wr1");
        applyStimulus(1'b1, 5'd5, 32'h11223344, 4'b0101, 1'b0, '0);
        tick("merge_wr2");
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd5);
        tick("merge_rd");
        check1("merge_const D32", bus_a.rd_data, 32'hAA22CC44);

        // Read-first collision at address 7.
        applyStimulus(1'b1, 5'd7, 32'h12345678, 4'hF, 1'b1, 5'd7);
        tick("collide");
        check1("collide_old D32", bus_a.rd_data, 32'h0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd7);
        tick("collide_next");
        check1("collide_new D32", bus_a.rd_data, 32'h12345678);

        // Out-of-range address on the DEPTH=20 copy.
        applyStimulus(1'b1, 5'd25, 32'hFFFFFFFF, 4'hF, 1'b0, '0);
        tick("oor_wr");
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd25);
        tick("oor_rd");
        check1("oor_data D20", bus_b.rd_data, 32'h0);
        check1("oor_valid D20", {31'b0, bus_b.rd_valid}, 32'h1);
        for (int a = 0; a < 20; a++) begin
            applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(a));
            tick("oor_scan");
        end

        for (int i = 0; i < 200; i++) begin
            applyRandom();
            tick("random");
        end

        // Reset in the middle of a read burst over non-zero data.
        for (int a = 0; a < 4; a++) begin
            applyStimulus(1'b1, AW'(a), 32'hC0DE0000 | 32'(a + 1), 4'hF, 1'b0, '0);
            tick("burst_wr");
        end
        for (int a = 0; a < 3; a++) begin
            applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(a));
            tick("burst_rd");
        end
        doReset("mid_reset");
        for (int i = 0; i < 34; i++) begin
            applyRandom();
            tick("reclear_rand");
        end
        for (int a = 0; a < 32; a++) begin
            applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(a));
            tick("reread");
        end
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0);
        tick("idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dp_mem_init.md
DP_MEM_INIT -- requirements
Module: dp_mem_init

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of words (any value >= 2, not necessarily a power of two).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width in bits, a multiple of 8.
REQ-003 SHALL derive ADDR_WIDTH = $clog2(DEPTH) and BE_WIDTH = DATA_WIDTH/8 as local parameters.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have wr_en  input  1  write request, port A.
REQ-006 SHALL have wr_addr  input  ADDR_WIDTH  write word address.
REQ-007 SHALL have wr_data  input  DATA_WIDTH  write data.
REQ-008 SHALL have wr_be  input  BE_WIDTH  byte enables; bit i qualifies wr_data[8i+7:8i].
REQ-009 SHALL have rd_en  input  1  read request, port B.
REQ-010 SHALL have rd_addr  input  ADDR_WIDTH  read word address.
REQ-011 SHALL have rd_data  output  DATA_WIDTH  registered read data.
REQ-012 SHALL have rd_valid  output  1  rd_data holds a result, one-cycle pulse.
REQ-013 SHALL have ready  output  1  initialisation complete; requests accepted.

Function
REQ-014 SHALL run a two-state FSM: CLEAR (state on reset) and RUN.
REQ-015 In CLEAR, SHALL write all-zero words to consecutive addresses 0..DEPTH-1, one per cycle, using an internal counter starting at 0.
REQ-016 SHALL move from CLEAR to RUN on the cycle that clears address DEPTH-1; total clear time is exactly DEPTH cycles after reset deassertion.
REQ-017 SHALL hold ready=0 in CLEAR and ready=1 in RUN, registered.
REQ-018 In CLEAR, SHALL ignore wr_en and rd_en completely: no user write, rd_valid stays 0.
REQ-019 In RUN, with wr_en=1, SHALL update byte i of mem[wr_addr] only where wr_be[i]=1; other bytes retain their value; wr_be=0 is a no-op.
REQ-020 In RUN, with rd_en=1, SHALL present mem[rd_addr] on rd_data and assert rd_valid exactly one cycle after the request (latency 1).
REQ-021 SHALL hold rd_data at its last value when rd_en=0; rd_valid SHALL be 0 that cycle.
REQ-022 Back-to-back reads SHALL be accepted every cycle with one result per cycle, in order.
REQ-023 Simultaneous write and read to the same address SHALL be read-first: rd_data returns the pre-write word; the new value is visible from the next read.
REQ-024 Simultaneous write and read to different addresses SHALL both complete with no interaction.
REQ-025 When DEPTH is not a power of two, a write with wr_addr >= DEPTH SHALL be discarded and a read with rd_addr >= DEPTH SHALL return all zeros with rd_valid=1.
REQ-026 The clear counter SHALL stop at DEPTH-1 and SHALL NOT wrap.

Reset
REQ-027 On rst=1, asynchronously: state=CLEAR, clear counter=0, ready=0, rd_valid=0, rd_data=0.
REQ-028 Memory contents SHALL NOT be reset asynchronously; they are zeroed only by the CLEAR sweep.
REQ-029 Reset asserted mid-RUN or mid-CLEAR SHALL abort the current operation and restart the full sweep from address 0 after deassertion; no in-flight read SHALL produce rd_valid.

Verification
REQ-030 Defaults: pulse rst, release -> ready=0 for 32 cycles then 1; reads of all 32 addresses -> 0x00000000, each with rd_valid one cycle after rd_en.
REQ-031 Write 0xAABBCCDD wr_be=4'hF at addr 5, then 0x11223344 wr_be=4'b0101 at addr 5, read addr 5 -> 0xAA22CC44.
REQ-032 Same-cycle write 0x12345678 and read at addr 7 (holding 0) -> rd_data=0x00000000; next read -> 0x12345678.
REQ-033 DEPTH=20: write 0xFFFFFFFF to addr 25 -> ignored; read addr 25 -> 0, rd_valid=1; addr 0..19 unaffected; ready rises 20 cycles after reset.
REQ-034 Write non-zero data, assert rst mid-read burst -> rd_valid drops immediately, ready=0 for DEPTH cycles, subsequent reads return 0.
REQ-035 Drive wr_en/rd_en during CLEAR -> no rd_valid, memory reads 0 after ready.
